// File: rtl/mmcm_servo_pkg.sv
// Shared types and constants for the MMCM dynamic phase-shift servo.
package mmcm_servo_pkg;

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StTrack    = 3'd1,
        StStep     = 3'd2,
        StWaitDone = 3'd3,
        StSettle   = 3'd4
    } servo_state_t;

    localparam logic PS_INC = 1'b1;
    localparam logic PS_DEC = 1'b0;

    localparam int unsigned PS_STEPS_PER_VCO = 56;

endpackage

// File: rtl/mmcm_ps_err_acc.sv
// Saturating signed up/down error integrator with threshold detection.
module mmcm_ps_err_acc #(
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned THRESH = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    input  logic up,
    input  logic dn,
    output logic ge_thresh,
    output logic le_nthresh
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ACC_ONE = 1;
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;

    logic signed [ACC_W-1:0] acc_q, acc_d;

    // Simultaneous up and down cancel out.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (!hold && up && !dn) begin
            acc_d = (acc_q == ACC_MAX) ? acc_q : acc_q + ACC_ONE;
        end else if (!hold && dn && !up) begin
            acc_d = (acc_q == ACC_MIN) ? acc_q : acc_q - ACC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign ge_thresh  = (acc_q >= THR_P);
    assign le_nthresh = (acc_q <= THR_N);

endmodule

// File: rtl/mmcm_ps_servo_ctrl.sv
// Closed-loop MMCM fine phase-shift sequencer: integrates detector pulses and
// issues single PSEN steps, tracking net offset, limits and PSDONE timeouts.
module mmcm_ps_servo_ctrl
    import mmcm_servo_pkg::*;
#(
    parameter int unsigned ACC_W       = 12,
    parameter int unsigned THRESH      = 64,
    parameter int unsigned OFS_W       = 16,
    parameter int unsigned MAX_OFFSET  = 4480,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    clk_in,
    input  logic                    reset_in_n,
    input  logic                    enable,
    input  logic                    mmcm_locked,
    input  logic                    lead_pulse,
    input  logic                    lag_pulse,
    input  logic                    clr_err,
    output logic                    psen,
    output logic                    psincdec,
    input  logic                    psdone,
    output logic signed [OFS_W-1:0] phase_offset,
    output logic                    ps_busy,
    output logic                    limit_hit,
    output logic                    timeout_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]        TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
    localparam logic signed [OFS_W-1:0] OFS_MAX     = OFS_W'(MAX_OFFSET);
    localparam logic signed [OFS_W-1:0] OFS_MIN     = -OFS_MAX;
    localparam logic signed [OFS_W-1:0] OFS_ONE     = 1;

    servo_state_t            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OFS_W-1:0] ofs_q, ofs_d;
    logic                    psen_q, psen_d;
    logic                    dir_q, dir_d;
    logic                    limit_q, limit_d;
    logic                    tmo_q, tmo_d;
    logic                    limit_set, tmo_set;

    logic acc_clr, acc_hold, acc_ge, acc_le;
    logic want_inc, want_dec, step_req, at_limit;

    assign want_inc = (state_q == StTrack) && enable && acc_ge;
    assign want_dec = (state_q == StTrack) && enable && acc_le && !acc_ge;
    assign step_req = want_inc || want_dec;
    assign at_limit = want_inc ? (ofs_q == OFS_MAX) : (ofs_q == OFS_MIN);

    // Integrate only while tracking; every decision restarts the integral from zero.
    assign acc_clr  = !mmcm_locked || (state_q == StWaitLock) ||
                      ((state_q == StTrack) && (!enable || step_req));
    assign acc_hold = (state_q != StTrack);

    mmcm_ps_err_acc #(
        .ACC_W  (ACC_W),
        .THRESH (THRESH)
    ) u_err_acc (
        .clk        (clk_in),
        .rst_n      (reset_in_n),
        .clr        (acc_clr),
        .hold       (acc_hold),
        .up         (lead_pulse),
        .dn         (lag_pulse),
        .ge_thresh  (acc_ge),
        .le_nthresh (acc_le)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ofs_d     = ofs_q;
        psen_d    = 1'b0;
        dir_d     = dir_q;
        limit_set = 1'b0;
        tmo_set   = 1'b0;

        case (state_q)
            StWaitLock: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StTrack;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StTrack: begin
                if (step_req) begin
                    if (at_limit) begin
                        limit_set = 1'b1;
                    end else begin
                        state_d = StStep;
                        psen_d  = 1'b1;
                        dir_d   = want_inc ? PS_INC : PS_DEC;
                    end
                end
            end
            StStep: begin
                // Counter counts cycles since psen, so it starts at 1 in WAIT_DONE.
                state_d = StWaitDone;
                cnt_d   = CNT_ONE;
            end
            StWaitDone: begin
                if (psdone) begin
                    ofs_d   = (dir_q == PS_INC) ? ofs_q + OFS_ONE : ofs_q - OFS_ONE;
                    state_d = StSettle;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_set = 1'b1;
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StTrack;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase

        // A re-lock resets the MMCM phase, so the offset bookkeeping restarts too.
        if (!mmcm_locked) begin
            state_d   = StWaitLock;
            cnt_d     = '0;
            ofs_d     = '0;
            psen_d    = 1'b0;
            limit_set = 1'b0;
            tmo_set   = 1'b0;
        end

        limit_d = limit_set || (limit_q && !clr_err);
        tmo_d   = tmo_set || (tmo_q && !clr_err);
    end

    always_ff @(posedge clk_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            ofs_q   <= '0;
            psen_q  <= 1'b0;
            dir_q   <= 1'b0;
            limit_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ofs_q   <= ofs_d;
            psen_q  <= psen_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            tmo_q   <= tmo_d;
        end
    end

    assign psen         = psen_q;
    assign psincdec     = dir_q;
    assign phase_offset = ofs_q;
    assign ps_busy      = (state_q == StStep) || (state_q == StWaitDone) ||
                          (state_q == StSettle);
    assign limit_hit    = limit_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_mmcm_ps_servo_ctrl.sv
// Directed bench for mmcm_ps_servo_ctrl; limit shrunk to 8 steps to keep the preload short.
module tb_mmcm_ps_servo_ctrl;

    localparam int MAX_OFS = 8;

    logic               clk_in = 1'b0;
    logic               reset_in_n;
    logic               enable;
    logic               mmcm_locked;
    logic               lead_pulse;
    logic               lag_pulse;
    logic               clr_err;
    logic               psen;
    logic               psincdec;
    logic               psdone;
    logic signed [15:0] phase_offset;
    logic               ps_busy;
    logic               limit_hit;
    logic               timeout_err;

    int n_vec = 0;
    int n_err = 0;

    mmcm_ps_servo_ctrl #(
        .ACC_W       (12),
        .THRESH      (64),
        .OFS_W       (16),
        .MAX_OFFSET  (MAX_OFS),
        .SETTLE_CYC  (16),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk_in       (clk_in),
        .reset_in_n   (reset_in_n),
        .enable       (enable),
        .mmcm_locked  (mmcm_locked),
        .lead_pulse   (lead_pulse),
        .lag_pulse    (lag_pulse),
        .clr_err      (clr_err),
        .psen         (psen),
        .psincdec     (psincdec),
        .psdone       (psdone),
        .phase_offset (phase_offset),
        .ps_busy      (ps_busy),
        .limit_hit    (limit_hit),
        .timeout_err  (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulses(input int n, input logic ld, input logic lg);
        lead_pulse = ld;
        lag_pulse  = lg;
        repeat (n) tick();
        lead_pulse = 1'b0;
        lag_pulse  = 1'b0;
    endtask

    task automatic wait_psen(input int budget, output int waited);
        waited = 0;
        while (!psen && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    // Starts in the psen cycle; returns psdone after lat cycles.
    task automatic do_step(input int lat, output int busy, output int psens);
        busy  = 0;
        psens = 0;
        for (int c = 0; c < lat + 40; c++) begin
            if (ps_busy) busy++;
            if (psen) psens++;
            psdone = (c == lat);
            tick();
        end
        psdone = 1'b0;
    endtask

    task automatic quick_step(input logic inc);
        int w, b, p;
        pulses(64, inc, !inc);
        wait_psen(5, w);
        do_step(1, b, p);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psen"}, psen, 0);
        check({tag, "_psincdec"}, psincdec, 0);
        check({tag, "_offset"}, $signed(phase_offset), 0);
        check({tag, "_busy"}, ps_busy, 0);
        check({tag, "_limit"}, limit_hit, 0);
        check({tag, "_timeout"}, timeout_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, b, p, cnt;
        reset_in_n  = 1'b0;
        enable      = 1'b0;
        mmcm_locked = 1'b0;
        lead_pulse  = 1'b0;
        lag_pulse   = 1'b0;
        clr_err     = 1'b0;
        psdone      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        reset_in_n  = 1'b1;
        mmcm_locked = 1'b1;
        enable      = 1'b1;
        repeat (20) tick();

        // 64 leads -> one increment step, psdone 12 cycles after psen.
        pulses(64, 1'b1, 1'b0);
        check("t1_no_early_psen", psen, 0);
        wait_psen(5, w);
        check("t1_psen_latency", w, 1);
        check("t1_psincdec", psincdec, 1);
        do_step(12, b, p);
        check("t1_busy_cycles", b, 29);
        check("t1_psen_count", p, 1);
        check("t1_offset", $signed(phase_offset), 1);

        // Lag steps take the offset down to -1.
        pulses(64, 1'b0, 1'b1);
        wait_psen(5, w);
        check("t2_psen_latency", w, 1);
        check("t2_psincdec", psincdec, 0);
        do_step(12, b, p);
        check("t2_offset_a", $signed(phase_offset), 0);
        pulses(64, 1'b0, 1'b1);
        wait_psen(5, w);
        check("t2_psen_b", psen, 1);
        do_step(12, b, p);
        check("t2_offset_b", $signed(phase_offset), -1);

        cnt = 0;
        lead_pulse = 1'b1;
        lag_pulse  = 1'b1;
        for (int i = 0; i < 105; i++) begin
            if (i == 100) begin
                lead_pulse = 1'b0;
                lag_pulse  = 1'b0;
            end
            if (psen) cnt++;
            tick();
        end
        check("t2_both_no_psen", cnt, 0);

        enable = 1'b0;
        cnt = 0;
        lead_pulse = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (psen) cnt++;
            tick();
        end
        lead_pulse = 1'b0;
        check("t2_disabled_no_psen", cnt, 0);
        enable = 1'b1;

        // Withheld psdone -> timeout 1024 cycles after psen.
        pulses(64, 1'b1, 1'b0);
        wait_psen(5, w);
        check("t3_psen", psen, 1);
        w = 0;
        while (!timeout_err && w < 1100) begin
            tick();
            w++;
        end
        check("t3_timeout_cycles", w, 1024);
        check("t3_offset_kept", $signed(phase_offset), -1);
        check("t3_not_busy", ps_busy, 0);
        psdone = 1'b1;
        tick();
        psdone = 1'b0;
        check("t3_stray_psdone", $signed(phase_offset), -1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_clr_err", timeout_err, 0);
        repeat (20) tick();

        // Lock loss in WAIT_DONE, then re-lock with leads streaming in.
        pulses(64, 1'b1, 1'b0);
        wait_psen(5, w);
        check("t4_psen", psen, 1);
        repeat (2) tick();
        mmcm_locked = 1'b0;
        tick();
        check("t4_psen_low", psen, 0);
        check("t4_offset_zero", $signed(phase_offset), 0);
        check("t4_not_busy", ps_busy, 0);
        mmcm_locked = 1'b1;
        lead_pulse  = 1'b1;
        wait_psen(200, w);
        lead_pulse = 1'b0;
        check("t4_relock_to_psen", w, 81);
        check("t4_psincdec", psincdec, 1);
        do_step(3, b, p);
        check("t4_offset", $signed(phase_offset), 1);

        // Drive to +MAX_OFS, then an increment must be suppressed.
        for (int i = 0; i < MAX_OFS - 1; i++) quick_step(1'b1);
        check("t5_offset_max", $signed(phase_offset), MAX_OFS);
        check("t5_limit_clear", limit_hit, 0);
        pulses(64, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (psen) cnt++;
            tick();
        end
        check("t5_no_psen_at_limit", cnt, 0);
        check("t5_limit_hit", limit_hit, 1);
        pulses(64, 1'b0, 1'b1);
        wait_psen(5, w);
        check("t5_dec_psen", psen, 1);
        check("t5_dec_dir", psincdec, 0);
        do_step(1, b, p);
        check("t5_offset_dec", $signed(phase_offset), MAX_OFS - 1);
        check("t5_limit_sticky", limit_hit, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_limit_cleared", limit_hit, 0);
        quick_step(1'b1);
        check("t5_offset_max2", $signed(phase_offset), MAX_OFS);
        clr_err = 1'b1;
        pulses(64, 1'b1, 1'b0);
        tick();
        check("t5_set_beats_clr", limit_hit, 1);
        clr_err = 1'b0;
        tick();

        // Asynchronous reset while psen is high.
        pulses(64, 1'b0, 1'b1);
        wait_psen(5, w);
        check("t6_psen", psen, 1);
        check("t6_busy", ps_busy, 1);
        #2;
        reset_in_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick();
        reset_in_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmcm_ps_servo_ctrl.md
Name: mmcm_ps_servo_ctrl

Overview:
Closed-loop sequencer for the UltraScale MMCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE). It integrates lead/lag pulses from an external phase detector comparing the slave MMCM output against the reference clock. When the integrated error crosses a threshold, it issues one fine phase step and waits for PSDONE. It tracks the net phase offset, enforces offset limits, and recovers from MMCM lock loss and PSDONE timeouts. The block sits in the PSCLK domain beside the slave MMCM inside MMCM_slave_test.

Parameters:
ACC_W, 12, error accumulator width (signed)
THRESH, 64, |acc| at or above which a step is issued (1..2^(ACC_W-1)-1)
OFS_W, 16, phase_offset width (signed)
MAX_OFFSET, 4480, max |phase_offset| in PS steps (80 VCO periods x 56)
SETTLE_CYC, 16, post-step / post-lock quiet cycles
TIMEOUT_CYC, 1024, max cycles from psen to psdone

Ports:
clk_in  in  1  PSCLK, also the control clock
reset_in_n  in  1  asynchronous active-low reset
enable  in  1  servo enable; low = no new steps
mmcm_locked  in  1  slave MMCM LOCKED (pre-synchronised)
lead_pulse  in  1  1-cycle pulse: slave leads the reference
lag_pulse  in  1  1-cycle pulse: slave lags the reference
clr_err  in  1  clears sticky limit_hit and timeout_err
psen  out  1  to MMCM PSEN, 1-cycle pulse
psincdec  out  1  to MMCM PSINCDEC, valid with psen
psdone  in  1  from MMCM PSDONE
phase_offset  out  OFS_W  net signed steps applied since lock
ps_busy  out  1  high in STEP/WAIT_DONE/SETTLE
limit_hit  out  1  sticky: step suppressed at +/-MAX_OFFSET
timeout_err  out  1  sticky: psdone not seen within TIMEOUT_CYC

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=WAIT_LOCK. All outputs 0. acc=0, counters=0.
- States: WAIT_LOCK, TRACK, STEP, WAIT_DONE, SETTLE.
- Any state, mmcm_locked=0: next state WAIT_LOCK. acc=0 and phase_offset=0, because the MMCM re-lock resets the phase. psen forced 0. This has priority over everything else.
- WAIT_LOCK: count consecutive locked cycles. At SETTLE_CYC go to TRACK, counter cleared.
- TRACK with enable=1: acc += (lead_pulse - lag_pulse). Both pulses high = no change. acc saturates at +/-(2^(ACC_W-1)-1).
- TRACK with enable=0: acc held at 0.
- Step decision in TRACK, on the registered acc value:
  - acc >= THRESH: dir=inc.
  - acc <= -THRESH: dir=dec.
  - acc is cleared to 0 in the same cycle.
  - If phase_offset is already at +MAX_OFFSET (inc) or -MAX_OFFSET (dec): no step, limit_hit<=1, stay in TRACK.
  - Otherwise go to STEP.
- STEP: lasts one cycle. psen=1 and psincdec=dir, both registered outputs, so psen goes high the cycle after the decision. Timeout counter loaded. Next state WAIT_DONE.
- WAIT_DONE: lead/lag ignored. psincdec holds dir.
  - On psdone: phase_offset += (inc ? +1 : -1), go to SETTLE.
  - If TIMEOUT_CYC cycles elapse first: timeout_err<=1, phase_offset unchanged, go to WAIT_LOCK.
  - psdone seen in any other state is ignored.
- SETTLE: count SETTLE_CYC cycles with lead/lag ignored, then return to TRACK.
- enable falling mid-step: the step completes normally (WAIT_DONE, SETTLE), then TRACK with acc held at 0.
- clr_err: clears both sticky flags next cycle. If a set event occurs in the same cycle, the set wins.
- psen high at most one cycle per step. Minimum step spacing = 1 + psdone latency + SETTLE_CYC.

Decomposition:
- mmcm_servo_pkg:
  - state enum servo_state_t
  - PS_INC=1'b1, PS_DEC=1'b0
  - PS_STEPS_PER_VCO=56
- Sub-module mmcm_ps_err_acc: saturating signed up/down accumulator with hold/clear inputs and ge_thresh/le_nthresh outputs. Parameters ACC_W and THRESH.
- FSM, counters and offset register stay in the top module.

Test Plan:
- Lock, enable=1, 64 lead pulses -> single psen with psincdec=1. Return psdone 12 cycles later -> phase_offset=+1, ps_busy high for 1+12+16 cycles.
- 64 lag pulses, then psdone -> psincdec=0, phase_offset=-1. 100 cycles of simultaneous lead+lag -> no psen.
- Withhold psdone -> timeout_err=1 exactly 1024 cycles after psen, state WAIT_LOCK, phase_offset unchanged. Pulse clr_err -> timeout_err=0.
- Drop mmcm_locked during WAIT_DONE -> psen=0 and phase_offset=0 next cycle. Re-lock -> TRACK after 16 cycles.
- Preload via 4480 inc steps (MAX_OFFSET=4480) -> next 64 leads give no psen, limit_hit=1. 64 lags still step: offset 4479.
- Async reset_in_n low mid-STEP -> all outputs 0 immediately, without waiting for a clock edge.
